i_route_split: RTL and testbench

I_ROUTE_SPLIT -- requirements
Module: i_route_split

---
 rtl/i_route_split_pkg.sv | 27 ++
 rtl/double_latch.sv | 51 +++++
 rtl/i_route_split.sv | 112 +++++++++++
 tb/tb_i_route_split.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_route_split_pkg.sv
// Shared interconnect definitions for the route split/merge blocks:
// route-bit position, SRC_ID field, port IDs and the route-pop helper.
package i_route_split_pkg;

    localparam int DATA_W     = 64;
    localparam int BUF_W      = DATA_W + 1;
    localparam int ROUTE_BIT  = 48;
    localparam int SRC_ID_LSB = 48;
    localparam int SRC_ID_MSB = 55;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    // Consumes the route bit: SRC_ID shifts down one, a zero enters at the top.
    function automatic logic [DATA_W-1:0] pop_route(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        r[SRC_ID_MSB:SRC_ID_LSB] = {1'b0, d[SRC_ID_MSB:SRC_ID_LSB+1]};
        return r;
    endfunction

endpackage

// File: rtl/double_latch.sv
// Two-entry skid buffer; s_ready depends only on its own occupancy, so
// full throughput is kept without a combinational path from m_ready.
module double_latch #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign s_ready = (count != 2'd2);
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i_route_split.sv
// Packet router: one inbound stream split to two outputs by header bit 48.
// Define I_ROUTE_SPLIT_STATS_EN to add per-port delivered-packet counters.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_HDR  | next accepted beat is a header; route from I_TDATA[48]
// ST_BODY | forwarding body beats to latched dir until TLAST
module i_route_split
    import i_route_split_pkg::*;
#(
    parameter int POP_ROUTE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              I_TVALID,
    output logic              I_TREADY,
    input  logic [DATA_W-1:0] I_TDATA,
    input  logic              I_TLAST,
    output logic              O0_TVALID,
    input  logic              O0_TREADY,
    output logic [DATA_W-1:0] O0_TDATA,
    output logic              O0_TLAST,
`ifdef I_ROUTE_SPLIT_STATS_EN
    output logic [15:0]       pkt_count0,
    output logic [15:0]       pkt_count1,
`endif
    output logic              O1_TVALID,
    input  logic              O1_TREADY,
    output logic [DATA_W-1:0] O1_TDATA,
    output logic              O1_TLAST
);

    state_t            state;
    logic              dir;
    logic              sel;
    logic              accept;
    logic              rdy0;
    logic              rdy1;
    logic [DATA_W-1:0] fwd_data;
    logic [BUF_W-1:0]  q0;
    logic [BUF_W-1:0]  q1;

    // Only the selected buffer's ready reaches I_TREADY (head-of-line blocking).
    assign sel      = (state == ST_HDR) ? I_TDATA[ROUTE_BIT] : dir;
    assign I_TREADY = (sel == PORT1) ? rdy1 : rdy0;
    assign accept   = I_TVALID && I_TREADY;

    always_comb begin
        fwd_data = I_TDATA;
        if ((POP_ROUTE != 0) && (state == ST_HDR)) begin
            fwd_data = pop_route(I_TDATA);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HDR;
            dir   <= PORT0;
        end else if (accept) begin
            case (state)
                ST_HDR: begin
                    dir <= I_TDATA[ROUTE_BIT];
                    if (!I_TLAST) state <= ST_BODY;
                end
                ST_BODY: begin
                    if (I_TLAST) state <= ST_HDR;
                end
                default: state <= ST_HDR;
            endcase
        end
    end

    double_latch #(.WIDTH(BUF_W)) u_buf0 (
        .clk     (clk),
        .reset   (reset),
        .s_valid (accept && (sel == PORT0)),
        .s_ready (rdy0),
        .s_data  ({I_TLAST, fwd_data}),
        .m_valid (O0_TVALID),
        .m_ready (O0_TREADY),
        .m_data  (q0)
    );

    double_latch #(.WIDTH(BUF_W)) u_buf1 (
        .clk     (clk),
        .reset   (reset),
        .s_valid (accept && (sel == PORT1)),
        .s_ready (rdy1),
        .s_data  ({I_TLAST, fwd_data}),
        .m_valid (O1_TVALID),
        .m_ready (O1_TREADY),
        .m_data  (q1)
    );

    assign O0_TDATA = q0[DATA_W-1:0];
    assign O0_TLAST = q0[DATA_W];
    assign O1_TDATA = q1[DATA_W-1:0];
    assign O1_TLAST = q1[DATA_W];

`ifdef I_ROUTE_SPLIT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count0 <= 16'd0;
            pkt_count1 <= 16'd0;
        end else begin
            if (O0_TVALID && O0_TREADY && O0_TLAST) pkt_count0 <= pkt_count0 + 16'd1;
            if (O1_TVALID && O1_TREADY && O1_TLAST) pkt_count1 <= pkt_count1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i_route_split.sv
// Self-checking bench for i_route_split (POP_ROUTE=1): vector table, directed
// corner sequences and a randomized run against a queue-based packet model.
module tb_i_route_split;

    logic        clk = 1'b0;
    logic        reset;
    logic        I_TVALID;
    logic        I_TREADY;
    logic [63:0] I_TDATA;
    logic        I_TLAST;
    logic        O0_TVALID, O0_TREADY, O0_TLAST;
    logic [63:0] O0_TDATA;
    logic        O1_TVALID, O1_TREADY, O1_TLAST;
    logic [63:0] O1_TDATA;
`ifdef I_ROUTE_SPLIT_STATS_EN
    logic [15:0] pkt_count0, pkt_count1;
`endif

    always #5 clk = ~clk;

    i_route_split #(.POP_ROUTE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .I_TVALID  (I_TVALID),
        .I_TREADY  (I_TREADY),
        .I_TDATA   (I_TDATA),
        .I_TLAST   (I_TLAST),
        .O0_TVALID (O0_TVALID),
        .O0_TREADY (O0_TREADY),
        .O0_TDATA  (O0_TDATA),
        .O0_TLAST  (O0_TLAST),
`ifdef I_ROUTE_SPLIT_STATS_EN
        .pkt_count0(pkt_count0),
        .pkt_count1(pkt_count1),
`endif
        .O1_TVALID (O1_TVALID),
        .O1_TREADY (O1_TREADY),
        .O1_TDATA  (O1_TDATA),
        .O1_TLAST  (O1_TLAST)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Header rewrite: the SRC_ID byte [55:48] is shifted right by one.
    function automatic logic [63:0] exp_hdr(input logic [63:0] d);
        logic [63:0] r;
        r = d;
        r[55:48] = d[55:48] >> 1;
        return r;
    endfunction

    // Output monitor: records delivered beats and checks hold-while-stalled.
    logic [64:0] got0[$];
    logic [64:0] got1[$];
    logic        pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0, prst = 1'b1;
    logic [64:0] pd0, pd1;

    always @(negedge clk) begin
        if (!prst && !reset) begin
            if (pv0 && !pr0) begin
                check("o0_hold_valid", 65'(O0_TVALID), 65'd1);
                check("o0_hold_data", {O0_TLAST, O0_TDATA}, pd0);
            end
            if (pv1 && !pr1) begin
                check("o1_hold_valid", 65'(O1_TVALID), 65'd1);
                check("o1_hold_data", {O1_TLAST, O1_TDATA}, pd1);
            end
        end
        if (!reset) begin
            if (O0_TVALID && O0_TREADY) got0.push_back({O0_TLAST, O0_TDATA});
            if (O1_TVALID && O1_TREADY) got1.push_back({O1_TLAST, O1_TDATA});
        end
        pv0 = O0_TVALID; pr0 = O0_TREADY; pd0 = {O0_TLAST, O0_TDATA};
        pv1 = O1_TVALID; pr1 = O1_TREADY; pd1 = {O1_TLAST, O1_TDATA};
        prst = reset;
    end

    logic rnd_ready = 1'b0;
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            O0_TREADY = 1'($urandom_range(0, 1));
            O1_TREADY = 1'($urandom_range(0, 1));
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_beat(input logic [63:0] d, input logic l, input int budget);
        logic ok;
        ok = 1'b0;
        I_TVALID = 1'b1;
        I_TDATA  = d;
        I_TLAST  = l;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (I_TREADY) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        I_TVALID = 1'b0;
        check("beat_accepted", 65'(ok), 65'd1);
    endtask

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        port;
        logic [63:0] exp_data;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s[4];
        logic [64:0] e[4];
        logic [64:0] exp0[$];
        logic [64:0] exp1[$];
        logic [64:0] act;
        int          idx;
        logic        acc;
        int          len;
        logic        dest;
        logic [63:0] d;

        vecs[0] = '{64'hAB06_1111_2222_3333, 1'b0, 1'b0, 64'hAB03_1111_2222_3333};
        vecs[1] = '{64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 64'h0000_0000_DEAD_BEEF};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{64'h0001_0000_0000_00AA, 1'b1, 1'b1, 64'h0000_0000_0000_00AA};
        vecs[4] = '{64'h00FE_0000_0000_0001, 1'b0, 1'b0, 64'h007F_0000_0000_0001};
        vecs[5] = '{64'h0000_0000_0000_0005, 1'b1, 1'b0, 64'h0000_0000_0000_0005};
        vecs[6] = '{64'hC3FF_0000_0000_0002, 1'b0, 1'b1, 64'hC37F_0000_0000_0002};
        vecs[7] = '{64'h0001_0000_0000_0000, 1'b1, 1'b1, 64'h0001_0000_0000_0000};
        vecs[8] = '{64'h0002_0000_0000_0007, 1'b0, 1'b0, 64'h0001_0000_0000_0007};
        vecs[9] = '{64'h0001_0000_0000_0008, 1'b1, 1'b0, 64'h0001_0000_0000_0008};

        reset = 1'b1; I_TVALID = 1'b0; I_TDATA = '0; I_TLAST = 1'b0;
        O0_TREADY = 1'b1; O1_TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_o0_valid", 65'(O0_TVALID), 65'd0);
        check("rst_o1_valid", 65'(O1_TVALID), 65'd0);
        check("rst_i_tready", 65'(I_TREADY), 65'd1);
`ifdef I_ROUTE_SPLIT_STATS_EN
        check("rst_pkt_count0", 65'(pkt_count0), 65'd0);
        check("rst_pkt_count1", 65'(pkt_count1), 65'd0);
`endif
        @(posedge clk); #1;

        // Table: back-to-back beats, both outputs ready, 1-cycle latency.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                I_TVALID = 1'b1; I_TDATA = vecs[i].data; I_TLAST = vecs[i].last;
            end else begin
                I_TVALID = 1'b0;
            end
            @(negedge clk);
            if (i < NV) check("tbl_tready", 65'(I_TREADY), 65'd1);
            if (i > 0) begin
                act = vecs[i-1].port ? {O1_TLAST, O1_TDATA} : {O0_TLAST, O0_TDATA};
                check("tbl_valid", 65'(vecs[i-1].port ? O1_TVALID : O0_TVALID), 65'd1);
                check("tbl_other_idle", 65'(vecs[i-1].port ? O0_TVALID : O1_TVALID), 65'd0);
                check("tbl_beat", act, {vecs[i-1].last, vecs[i-1].exp_data});
            end
            @(posedge clk); #1;
        end

        // Stall O0 for 10 cycles during a 4-beat packet.
        repeat (2) @(posedge clk); #1;
        got0.delete(); got1.delete();
        s[0] = 64'h0004_0000_0000_0010; s[1] = 64'h11; s[2] = 64'h22; s[3] = 64'h33;
        e[0] = {1'b0, exp_hdr(s[0])}; e[1] = {1'b0, s[1]}; e[2] = {1'b0, s[2]}; e[3] = {1'b1, s[3]};
        O0_TREADY = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            I_TVALID = 1'b1; I_TDATA = s[idx]; I_TLAST = (idx == 3);
            @(negedge clk);
            acc = I_TREADY;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("stall_accepted", 65'(idx), 65'd2);
        @(negedge clk);
        check("stall_tready_low", 65'(I_TREADY), 65'd0);
        check("stall_o0_head", {O0_TLAST, O0_TDATA}, e[0]);
        @(posedge clk); #1;
        O0_TREADY = 1'b1;
        while (idx < 4) begin
            send_beat(s[idx], idx == 3, 20);
            idx++;
        end
        repeat (4) @(posedge clk); #1;
        check("stall_count", 65'(got0.size()), 65'd4);
        check("stall_o1_count", 65'(got1.size()), 65'd0);
        for (int k = 0; k < 4 && k < got0.size(); k++) check("stall_order", got0[k], e[k]);

        // Reset after the header of a 3-beat packet.
        got0.delete(); got1.delete();
        O0_TREADY = 1'b0;
        send_beat(64'h0000_0000_0000_0A0A, 1'b0, 5);
        @(negedge clk);
        check("rstmid_hdr_buffered", 65'(O0_TVALID), 65'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rstmid_o0_valid", 65'(O0_TVALID), 65'd0);
        check("rstmid_o1_valid", 65'(O1_TVALID), 65'd0);
        @(posedge clk); #1;
        O0_TREADY = 1'b1;
        send_beat(64'h0003_0000_0000_0B0B, 1'b1, 5);
        repeat (3) @(posedge clk); #1;
        check("rstmid_o1_count", 65'(got1.size()), 65'd1);
        check("rstmid_o0_count", 65'(got0.size()), 65'd0);
        if (got1.size() > 0) check("rstmid_o1_beat", got1[0], {1'b1, 64'h0001_0000_0000_0B0B});

        // Randomized packets with random output back-pressure.
        got0.delete(); got1.delete();
        rnd_ready = 1'b1;
        for (int p = 0; p < 60; p++) begin
            len  = $urandom_range(1, 4);
            dest = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                d = {$urandom, $urandom};
                if (b == 0) d[48] = dest;
                act = {(b == len - 1), (b == 0) ? exp_hdr(d) : d};
                if (dest) exp1.push_back(act); else exp0.push_back(act);
                send_beat(d, b == len - 1, 200);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end
        rnd_ready = 1'b0;
        @(posedge clk); #2;
        O0_TREADY = 1'b1; O1_TREADY = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("rnd_o0_count", 65'(got0.size()), 65'(exp0.size()));
        check("rnd_o1_count", 65'(got1.size()), 65'(exp1.size()));
        for (int k = 0; k < exp0.size() && k < got0.size(); k++) check("rnd_o0_beat", got0[k], exp0[k]);
        for (int k = 0; k < exp1.size() && k < got1.size(); k++) check("rnd_o1_beat", got1[k], exp1[k]);

`ifdef I_ROUTE_SPLIT_STATS_EN
        // Counter wrap: 65537 single-beat packets to O1.
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        got0.delete(); got1.delete();
        idx = 0;
        I_TVALID = 1'b1; I_TDATA = 64'h0001_0000_0000_0000; I_TLAST = 1'b1;
        for (int c = 0; c < 70000 && idx < 65537; c++) begin
            @(negedge clk);
            if (I_TREADY) idx++;
            @(posedge clk); #1;
        end
        I_TVALID = 1'b0;
        check("stats_sent", 65'(idx), 65'd65537);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stats_pkt_count1", 65'(pkt_count1), 65'd1);
        check("stats_pkt_count0", 65'(pkt_count0), 65'd0);
        got1.delete();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
